inta_sequencer: RTL and testbench
=================================

Name: inta_sequencer

Overview:
- Interrupt-acknowledge sequencer for the 8259A-compatible PIC, 8086 mode only (two INTA pulses).
- Sits between the priority resolver and the data-bus buffer.
- Raises INT to the CPU, freezes the winning level on the first INTA pulse, and drives the cascade lines (master) or checks them (slave).
- On the second INTA pulse it drives the interrupt vector byte, and it emits ISR set/clear pulses to the in-service register.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising INTA_N to CLK (minimum 2).
- SPURIOUS_LEVEL, 7: level reported when no request is valid at the first INTA.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- INTA_N  in  1  CPU acknowledge strobe, active low, asynchronous to CLK.
- INT_REQ  in  1  priority resolver has an unmasked, unserviced winner.
- REQ_LEVEL  in  3  winning IR level (valid when INT_REQ=1).
- ICW2_BASE  in  5  vector bits T7..T3.
- SP  in  1  1=master, 0=slave.
- SNGL  in  1  single mode (no cascade).
- CASCADE_MAP  in  8  master ICW3: bit n=1 means a slave is on IRn.
- SLAVE_ID  in  3  slave ICW3 ID.
- CAS_IN  in  3  cascade lines as seen on the pins.
- AEOI  in  1  auto end-of-interrupt enable.
- INT  out  1  interrupt request to CPU.
- CAS_OUT  out  3  cascade ID driven by the master.
- CAS_OE  out  1  cascade driver enable.
- DATA_OUT  out  8  vector byte.
- DATA_OE  out  1  data-bus driver enable.
- ISR_SET  out  8  one-hot, one-cycle pulse: set the ISR bit.
- ISR_CLR  out  8  one-hot, one-cycle pulse: clear the ISR bit (AEOI).

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - All outputs are 0.
  - State is IDLE; synchroniser flops are 1 (INTA inactive); latched level, spurious and responsible flags are 0.
  - Reset wins over every other event, including mid-sequence. The bus drivers are released within one cycle.
- INTA handling:
  - INTA_N passes through SYNC_STAGES flops, then one edge-detect register.
  - fall = sync low and previous high; rise = sync high and previous low.
  - All outputs are registered. An INTA_N pin edge affects outputs SYNC_STAGES+1 cycles later.
- States: IDLE, REQ, ACK1, GAP, ACK2.
- IDLE:
  - INT_REQ=1 → REQ; INT=1 next cycle.
  - fall → ACK1 with spurious=1.
- REQ:
  - INT=1.
  - INT_REQ dropping returns to IDLE and sets INT=0.
  - fall → ACK1. If INT_REQ=1 in that same cycle, latch REQ_LEVEL; otherwise latch SPURIOUS_LEVEL with spurious=1.
- ACK1 (entered on the first fall):
  - INT=0.
  - If not spurious, ISR_SET[level]=1 for exactly one cycle. Spurious never sets the ISR.
  - Master with SNGL=0 and CASCADE_MAP[level]=1 and not spurious: CAS_OUT=level and CAS_OE=1, held until the end of ACK2. Otherwise CAS_OUT=0 and CAS_OE=0.
  - rise → GAP.
- GAP:
  - Wait for fall → ACK2.
  - Changes on REQ_LEVEL/INT_REQ are ignored; the level is frozen.
- ACK2 (entered on the second fall):
  - responsible is computed in the entry cycle:
    - master: SNGL=1, or CASCADE_MAP[level]=0, or spurious;
    - slave: CAS_IN==SLAVE_ID, sampled in the entry cycle.
  - If responsible: DATA_OUT={ICW2_BASE, level} and DATA_OE=1 until rise. Otherwise DATA_OE=0 and DATA_OUT=0.
  - On rise:
    - DATA_OE=0, CAS_OE=0, CAS_OUT=0.
    - If AEOI=1 and not spurious, ISR_CLR[level]=1 for one cycle.
    - Go to IDLE, or to REQ if INT_REQ=1 in that cycle.
    - Clear the spurious flag.
- Simultaneous events: a fall and an INT_REQ deassert in the same cycle give a spurious sequence. ISR_SET and ISR_CLR are never asserted together.
- Slave: CAS_OE is always 0, and the slave takes part in sequences only through the CAS_IN match.

Test Plan:
- Master, SNGL=1, ICW2_BASE=5'b00001, INT_REQ=1, REQ_LEVEL=3 → INT=1; first INTA pulse gives ISR_SET=8'h08 for one cycle and INT=0; second pulse gives DATA_OE=1, DATA_OUT=8'h0B; DATA_OE=0 after rise.
- Master, SNGL=0, CASCADE_MAP=8'h04, REQ_LEVEL=2 → CAS_OUT=3'd2, CAS_OE=1 from first fall through second rise; DATA_OE stays 0 throughout.
- Slave, SLAVE_ID=2, CAS_IN=2, ICW2_BASE=5'b01000, REQ_LEVEL=5 → DATA_OUT=8'h45 on second pulse. Repeating with CAS_IN=3 → DATA_OE=0 and ISR_SET=8'h20 still pulsed.
- INT_REQ drops one cycle before first INTA fall (master, ICW2_BASE=5'b00010) → no ISR_SET; vector 8'h17 on second pulse.
- AEOI=1, level 6 → ISR_SET=8'h40 in ACK1, ISR_CLR=8'h40 one cycle at second rise; with AEOI=0, ISR_CLR stays 0.
- RST_N=0 during ACK2 with DATA_OE=1 → next cycle all outputs 0, state IDLE; a subsequent full sequence completes normally.

Source files
------------

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer for an 8259A-compatible PIC (8086 mode).
// It raises INT, freezes the level on the first INTA, and drives the vector on the second.
module inta_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int SPURIOUS_LEVEL = 7
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       INTA_N,
    input  logic       INT_REQ,
    input  logic [2:0] REQ_LEVEL,
    input  logic [4:0] ICW2_BASE,
    input  logic       SP,
    input  logic       SNGL,
    input  logic [7:0] CASCADE_MAP,
    input  logic [2:0] SLAVE_ID,
    input  logic [2:0] CAS_IN,
    input  logic       AEOI,
    output logic       INT,
    output logic [2:0] CAS_OUT,
    output logic       CAS_OE,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    output logic [7:0] ISR_SET,
    output logic [7:0] ISR_CLR
);

    localparam logic [2:0] SPUR_LEVEL = 3'(SPURIOUS_LEVEL);

    typedef enum logic [2:0] {IDLE, REQ, ACK1, GAP, ACK2} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   inta_s, fall, rise;
    logic [2:0]             level_q, level_n;
    logic                   spurious_q, spurious_n;
    logic                   resp_q, resp_n;
    logic                   enter_ack1;
    logic                   int_n, cas_oe_n, data_oe_n;
    logic [2:0]             cas_out_n;
    logic [7:0]             data_out_n, isr_set_n, isr_clr_n;

    // INTA_N is active low, so fall marks the start of an acknowledge pulse.
    assign inta_s = sync_q[SYNC_STAGES-1];
    assign fall   = !inta_s && prev_q;
    assign rise   = inta_s && !prev_q;

    always_comb begin
        state_n    = state;
        level_n    = level_q;
        spurious_n = spurious_q;
        resp_n     = resp_q;
        enter_ack1 = 1'b0;
        int_n      = INT;
        cas_out_n  = CAS_OUT;
        cas_oe_n   = CAS_OE;
        data_out_n = DATA_OUT;
        data_oe_n  = DATA_OE;
        isr_set_n  = '0;
        isr_clr_n  = '0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_n    = ACK1;
                    level_n    = SPUR_LEVEL;
                    spurious_n = 1'b1;
                    enter_ack1 = 1'b1;
                end else if (INT_REQ) begin
                    state_n = REQ;
                    int_n   = 1'b1;
                end
            end
            REQ: begin
                int_n = 1'b1;
                if (fall) begin
                    state_n    = ACK1;
                    enter_ack1 = 1'b1;
                    level_n    = INT_REQ ? REQ_LEVEL : SPUR_LEVEL;
                    spurious_n = !INT_REQ;
                end else if (!INT_REQ) begin
                    state_n = IDLE;
                    int_n   = 1'b0;
                end
            end
            ACK1: begin
                int_n = 1'b0;
                if (rise) state_n = GAP;
            end
            GAP: begin
                if (fall) begin
                    state_n    = ACK2;
                    resp_n     = SP ? (SNGL || !CASCADE_MAP[level_q] || spurious_q)
                                    : (CAS_IN == SLAVE_ID);
                    data_oe_n  = resp_n;
                    data_out_n = resp_n ? {ICW2_BASE, level_q} : 8'h00;
                end
            end
            ACK2: begin
                data_oe_n = resp_q;
                if (rise) begin
                    data_oe_n  = 1'b0;
                    data_out_n = 8'h00;
                    cas_oe_n   = 1'b0;
                    cas_out_n  = 3'd0;
                    if (AEOI && !spurious_q) isr_clr_n = 8'b1 << level_q;
                    spurious_n = 1'b0;
                    state_n    = INT_REQ ? REQ : IDLE;
                    int_n      = INT_REQ;
                end
            end
            default: state_n = IDLE;
        endcase

        // The cascade ID is only driven for a real (non-spurious) slave-backed level.
        if (enter_ack1) begin
            int_n    = 1'b0;
            cas_oe_n = SP && !SNGL && CASCADE_MAP[level_n] && !spurious_n;
            cas_out_n = cas_oe_n ? level_n : 3'd0;
            if (!spurious_n) isr_set_n = 8'b1 << level_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            sync_q     <= '1;
            prev_q     <= 1'b1;
            level_q    <= 3'd0;
            spurious_q <= 1'b0;
            resp_q     <= 1'b0;
            INT        <= 1'b0;
            CAS_OUT    <= 3'd0;
            CAS_OE     <= 1'b0;
            DATA_OUT   <= 8'h00;
            DATA_OE    <= 1'b0;
            ISR_SET    <= 8'h00;
            ISR_CLR    <= 8'h00;
        end else begin
            state      <= state_n;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], INTA_N};
            prev_q     <= inta_s;
            level_q    <= level_n;
            spurious_q <= spurious_n;
            resp_q     <= resp_n;
            INT        <= int_n;
            CAS_OUT    <= cas_out_n;
            CAS_OE     <= cas_oe_n;
            DATA_OUT   <= data_out_n;
            DATA_OE    <= data_oe_n;
            ISR_SET    <= isr_set_n;
            ISR_CLR    <= isr_clr_n;
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed acknowledge sequences followed by randomized ones,
// each checked against expectations derived from the acknowledge rules.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inta_n = 1'b1;
    logic       int_req = 1'b0;
    logic [2:0] req_level = 3'd0;
    logic [4:0] icw2_base = 5'd0;
    logic       sp = 1'b1;
    logic       sngl = 1'b1;
    logic [7:0] cascade_map = 8'h00;
    logic [2:0] slave_id = 3'd0;
    logic [2:0] cas_in = 3'd0;
    logic       aeoi = 1'b0;
    logic       int_o;
    logic [2:0] cas_out;
    logic       cas_oe;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] isr_set;
    logic [7:0] isr_clr;

    int vectors = 0;
    int miscompares = 0;

    inta_sequencer #(.SYNC_STAGES(2), .SPURIOUS_LEVEL(7)) dut (
        .CLK(clk), .RST_N(rst_n), .INTA_N(inta_n), .INT_REQ(int_req),
        .REQ_LEVEL(req_level), .ICW2_BASE(icw2_base), .SP(sp), .SNGL(sngl),
        .CASCADE_MAP(cascade_map), .SLAVE_ID(slave_id), .CAS_IN(cas_in), .AEOI(aeoi),
        .INT(int_o), .CAS_OUT(cas_out), .CAS_OE(cas_oe), .DATA_OUT(data_out),
        .DATA_OE(data_oe), .ISR_SET(isr_set), .ISR_CLR(isr_clr)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_int"}, 8'(int_o), 8'h00);
        chk({tag, "_cas_out"}, 8'(cas_out), 8'h00);
        chk({tag, "_cas_oe"}, 8'(cas_oe), 8'h00);
        chk({tag, "_dout"}, data_out, 8'h00);
        chk({tag, "_doe"}, 8'(data_oe), 8'h00);
        chk({tag, "_set"}, isr_set, 8'h00);
        chk({tag, "_clr"}, isr_clr, 8'h00);
    endtask

    // mode 0: normal request; 1: INT_REQ drops a cycle before the fall is seen;
    // 2: INT_REQ drops in the same cycle as the fall; 3: no request at all.
    task automatic run_seq(input logic sp_i, input logic sngl_i, input logic [7:0] map_i,
                           input logic [2:0] sid_i, input logic [2:0] cas_i,
                           input logic [4:0] base_i, input logic [2:0] lvl_i,
                           input int mode, input logic aeoi_i, input logic req_after,
                           input int w1, input int gap, input int w2);
        logic       spur;
        logic [2:0] lv;
        logic [7:0] onehot, exp_set, exp_clr, vec;
        logic       cas_on, resp;
        spur    = (mode != 0);
        lv      = spur ? 3'd7 : lvl_i;
        onehot  = 8'd1 << lv;
        exp_set = spur ? 8'h00 : onehot;
        exp_clr = (aeoi_i && !spur) ? onehot : 8'h00;
        cas_on  = sp_i && !sngl_i && map_i[lv] && !spur;
        resp    = sp_i ? (sngl_i || !map_i[lv] || spur) : (cas_i == sid_i);
        vec     = {base_i, lv};

        sp = sp_i; sngl = sngl_i; cascade_map = map_i; slave_id = sid_i;
        cas_in = cas_i; icw2_base = base_i; aeoi = aeoi_i; req_level = lvl_i;
        if (mode != 3) int_req = 1'b1;
        tick(1);
        chk("int_raise", 8'(int_o), 8'(mode != 3));

        inta_n = 1'b0;
        tick(1);
        if (mode == 1) int_req = 1'b0;
        tick(1);
        chk("int_pre_ack", 8'(int_o), 8'(mode == 0 || mode == 2));
        chk("set_latency", isr_set, 8'h00);
        if (mode == 2) int_req = 1'b0;
        tick(1);
        chk("ack1_int", 8'(int_o), 8'h00);
        chk("ack1_isr_set", isr_set, exp_set);
        chk("ack1_cas_oe", 8'(cas_oe), 8'(cas_on));
        chk("ack1_cas_out", 8'(cas_out), cas_on ? 8'(lv) : 8'h00);
        chk("ack1_doe", 8'(data_oe), 8'h00);
        int_req = 1'b0;
        req_level = 3'($urandom_range(0, 7));
        tick(1);
        chk("set_one_cycle", isr_set, 8'h00);
        tick(w1);

        inta_n = 1'b1;
        tick(3);
        chk("gap_cas_oe", 8'(cas_oe), 8'(cas_on));
        chk("gap_doe", 8'(data_oe), 8'h00);
        int_req = 1'($urandom_range(0, 1));
        req_level = 3'($urandom_range(0, 7));
        tick(gap);

        inta_n = 1'b0;
        tick(2);
        chk("doe_latency", 8'(data_oe), 8'h00);
        tick(1);
        chk("ack2_doe", 8'(data_oe), 8'(resp));
        chk("ack2_dout", data_out, resp ? vec : 8'h00);
        chk("ack2_cas_oe", 8'(cas_oe), 8'(cas_on));
        chk("ack2_int", 8'(int_o), 8'h00);
        chk("ack2_set", isr_set, 8'h00);
        cas_in = 3'($urandom_range(0, 7));
        int_req = req_after;
        tick(w2 + 1);
        chk("ack2_hold_doe", 8'(data_oe), 8'(resp));
        chk("ack2_hold_dout", data_out, resp ? vec : 8'h00);

        inta_n = 1'b1;
        tick(2);
        chk("rise_latency_doe", 8'(data_oe), 8'(resp));
        chk("clr_latency", isr_clr, 8'h00);
        tick(1);
        chk("end_doe", 8'(data_oe), 8'h00);
        chk("end_dout", data_out, 8'h00);
        chk("end_cas_oe", 8'(cas_oe), 8'h00);
        chk("end_cas_out", 8'(cas_out), 8'h00);
        chk("end_isr_clr", isr_clr, exp_clr);
        chk("end_set", isr_set, 8'h00);
        chk("end_int", 8'(int_o), 8'(req_after));
        tick(1);
        chk("clr_one_cycle", isr_clr, 8'h00);
        int_req = 1'b0;
        tick(1);
        chk("idle_int", 8'(int_o), 8'h00);
    endtask

    initial begin
        tick(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(2);
        chk_all_zero("post_reset");

        // Master, single mode, level 3, base 1: vector 0B.
        run_seq(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 5'b00001, 3'd3, 0, 1'b0, 1'b0, 1, 1, 1);
        // Master cascaded on IR2: drives CAS, never the data bus.
        run_seq(1'b1, 1'b0, 8'h04, 3'd0, 3'd0, 5'b00001, 3'd2, 0, 1'b0, 1'b0, 0, 2, 0);
        // Slave with matching and non-matching cascade ID.
        run_seq(1'b0, 1'b0, 8'h00, 3'd2, 3'd2, 5'b01000, 3'd5, 0, 1'b0, 1'b0, 1, 0, 1);
        run_seq(1'b0, 1'b0, 8'h00, 3'd2, 3'd3, 5'b01000, 3'd5, 0, 1'b0, 1'b0, 1, 0, 1);
        // Request withdrawn before the first fall: spurious vector 17.
        run_seq(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 5'b00010, 3'd4, 1, 1'b1, 1'b0, 0, 1, 0);
        // Same-cycle withdrawal and fall is spurious too.
        run_seq(1'b1, 1'b0, 8'hFF, 3'd0, 3'd0, 5'b00010, 3'd1, 2, 1'b1, 1'b0, 0, 1, 0);
        // Auto-EOI on level 6, then without it; then a follow-on request after rise.
        run_seq(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 5'b10101, 3'd6, 0, 1'b1, 1'b0, 1, 1, 1);
        run_seq(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 5'b10101, 3'd6, 0, 1'b0, 1'b1, 1, 1, 1);

        // Reset in the middle of the second pulse with the data bus driven.
        sp = 1'b1; sngl = 1'b1; icw2_base = 5'b00011; aeoi = 1'b1;
        int_req = 1'b1; req_level = 3'd4;
        tick(1);
        inta_n = 1'b0; tick(4);
        inta_n = 1'b1; tick(4);
        inta_n = 1'b0; tick(4);
        chk("pre_reset_doe", 8'(data_oe), 8'h01);
        chk("pre_reset_dout", data_out, 8'h1C);
        rst_n = 1'b0;
        tick(1);
        chk_all_zero("mid_reset");
        rst_n = 1'b1; inta_n = 1'b1; int_req = 1'b0;
        tick(4);
        chk_all_zero("after_reset");
        run_seq(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 5'b00011, 3'd4, 0, 1'b1, 1'b0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    3'($urandom_range(0, 7)), mode, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
